// File: rtl/instr_fetch_issue.sv
// Fetch/decode/issue front end for a multi-cycle MIPS core: one instruction in flight.
// Optional build macro ILLEGAL_OPCODE_TRAP_EN traps unknown opcodes into a HALT state.
module instr_fetch_issue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

`ifdef ILLEGAL_OPCODE_TRAP_EN
    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_RESOLVE, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_RESOLVE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              req_q, req_d;

    // Branch offset is a signed word count relative to the following instruction.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc,
                                                  input logic signed [15:0] off,
                                                  input logic taken);
        logic signed [ADDR_W-1:0] disp;
        disp = {{(ADDR_W-16){off[15]}}, off};
        return pc + ADDR_W'(4) + (taken ? (disp <<< 2) : '0);
    endfunction

`ifdef ILLEGAL_OPCODE_TRAP_EN
    function automatic logic legal_opcode(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) ||
               (op == 6'b101011) || (op == 6'b000100);
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        req_d   = req_q;
        case (state_q)
            S_FETCH: begin
                // An ack only counts once the request is actually on the bus.
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    req_d   = 1'b0;
                    state_d = S_ISSUE;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_ISSUE: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                if (!legal_opcode(ir_q[31:26])) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    state_d = S_RESOLVE;
                end
`else
                if (!stall) begin
                    state_d = S_RESOLVE;
                end
`endif
            end
            S_RESOLVE: begin
                pc_d    = next_pc(pc_q, ir_q[15:0], branch & zero);
                req_d   = 1'b1;
                state_d = S_FETCH;
            end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign func      = ir_q[5:0];
    assign imm       = ir_q[15:0];

`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign instr_valid = (state_q == S_ISSUE) && legal_opcode(ir_q[31:26]);
    assign halted      = (state_q == S_HALT);
`else
    assign instr_valid = (state_q == S_ISSUE);
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Scoreboard bench for instr_fetch_issue: a driver plays imem/Controller, a monitor checks each issue.
module tb_instr_fetch_issue;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] pc;
    } issue_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        halted;

    int     n_tests = 0;
    int     n_fail  = 0;
    issue_t exp_q[$];
    issue_t mon_e;
    logic   vld_prev = 1'b0;

    instr_fetch_issue #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch(branch), .zero(zero),
        .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every new issue must match the oldest pending expectation.
    always @(negedge clk) begin
        if (instr_valid && !vld_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: opcode %h at pc %h with empty scoreboard", opcode, pc_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_opcode", 32'(opcode), 32'(mon_e.op));
                check("issue_func",   32'(func),   32'(mon_e.fn));
                check("issue_rs",     32'(rs),     32'(mon_e.rs));
                check("issue_rt",     32'(rt),     32'(mon_e.rt));
                check("issue_rd",     32'(rd),     32'(mon_e.rd));
                check("issue_imm",    32'(imm),    32'(mon_e.imm));
                check("issue_pc",     pc_out,      mon_e.pc);
                check("issue_halted", 32'(halted), 32'd0);
            end
        end
        vld_prev = instr_valid;
    end

    task automatic wait_req(output logic ok);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = imem_req;
        if (!ok) check("req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic run_instr(input logic [31:0] word, input logic [31:0] addr,
                             input int nwait, input int nstall,
                             input logic br, input logic zr, input issue_t exp);
        logic ok;
        wait_req(ok);
        if (!ok) return;
        check("fetch_addr", imem_addr, addr);
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, addr);
        end
        exp_q.push_back(exp);
        imem_ack   = 1'b1;
        imem_rdata = word;
        stall      = (nstall > 0);
        branch     = br;
        zero       = zr;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid_latency", 32'(instr_valid), 32'd1);
        check("req_dropped", 32'(imem_req), 32'd0);
        for (int i = 0; i < nstall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_opcode", 32'(opcode), 32'(exp.op));
            check("stall_imm", 32'(imm), 32'(exp.imm));
            check("stall_pc", pc_out, exp.pc);
        end
        stall = 1'b0;
        @(negedge clk);
        check("resolve_valid", 32'(instr_valid), 32'd0);
    endtask

    // Release reset while a stray ack is present; it must be ignored.
    task automatic release_reset();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        #1;
        check("req_low_after_release", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("req_first_edge", 32'(imem_req), 32'd1);
        check("stray_ack_ignored", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        logic ok;
        repeat (2) @(negedge clk);
        check("rst_req",    32'(imem_req),    32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_fields", {opcode, func, rd, imm}, 32'd0);
        check("rst_pc",     pc_out,           32'h0);
        release_reset();

        run_instr(32'h0109_5020, 32'h0, 0, 0, 1'b0, 1'b0,
                  '{op:6'h00, fn:6'h20, rs:5'd8,  rt:5'd9,  rd:5'd10, imm:16'h5020, pc:32'h0});
        run_instr(32'h014B_6022, 32'h4, 3, 0, 1'b0, 1'b0,
                  '{op:6'h00, fn:6'h22, rs:5'd10, rt:5'd11, rd:5'd12, imm:16'h6022, pc:32'h4});
        run_instr(32'h8C88_0004, 32'h8, 0, 5, 1'b0, 1'b0,
                  '{op:6'h23, fn:6'h04, rs:5'd4,  rt:5'd8,  rd:5'd0,  imm:16'h0004, pc:32'h8});
        run_instr(32'h0000_0000, 32'hC, 0, 0, 1'b0, 1'b0,
                  '{op:6'h00, fn:6'h00, rs:5'd0,  rt:5'd0,  rd:5'd0,  imm:16'h0000, pc:32'hC});
        run_instr(32'h1000_FFFF, 32'h10, 0, 0, 1'b1, 1'b1,
                  '{op:6'h04, fn:6'h3F, rs:5'd0,  rt:5'd0,  rd:5'd31, imm:16'hFFFF, pc:32'h10});
        run_instr(32'h1000_FFFF, 32'h10, 0, 0, 1'b1, 1'b0,
                  '{op:6'h04, fn:6'h3F, rs:5'd0,  rt:5'd0,  rd:5'd31, imm:16'hFFFF, pc:32'h10});
        run_instr(32'h1000_0003, 32'h14, 1, 0, 1'b0, 1'b1,
                  '{op:6'h04, fn:6'h03, rs:5'd0,  rt:5'd0,  rd:5'd0,  imm:16'h0003, pc:32'h14});
        run_instr(32'h1000_0003, 32'h18, 0, 0, 1'b1, 1'b1,
                  '{op:6'h04, fn:6'h03, rs:5'd0,  rt:5'd0,  rd:5'd0,  imm:16'h0003, pc:32'h18});
        run_instr(32'h1000_0005, 32'h28, 0, 2, 1'b1, 1'b1,
                  '{op:6'h04, fn:6'h05, rs:5'd0,  rt:5'd0,  rd:5'd0,  imm:16'h0005, pc:32'h28});

        // Reset pulse while a fetch at 0x40 is outstanding.
        wait_req(ok);
        check("prereset_addr", imem_addr, 32'h40);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req",    32'(imem_req),    32'd0);
        check("midrst_valid",  32'(instr_valid), 32'd0);
        check("midrst_opcode", 32'(opcode),      32'd0);
        check("midrst_addr",   imem_addr,        32'h0);
        @(negedge clk);
        release_reset();

        run_instr(32'h1000_FFFE, 32'h0, 0, 0, 1'b1, 1'b1,
                  '{op:6'h04, fn:6'h3E, rs:5'd0,  rt:5'd0,  rd:5'd31, imm:16'hFFFE, pc:32'h0});
        run_instr(32'h0000_0000, 32'hFFFF_FFFC, 0, 0, 1'b0, 1'b0,
                  '{op:6'h00, fn:6'h00, rs:5'd0,  rt:5'd0,  rd:5'd0,  imm:16'h0000, pc:32'hFFFF_FFFC});

`ifdef ILLEGAL_OPCODE_TRAP_EN
        begin
            int bad_req, bad_vld;
            bad_req = 0;
            bad_vld = 0;
            wait_req(ok);
            check("trap_fetch_addr", imem_addr, 32'h0);
            imem_ack   = 1'b1;
            imem_rdata = 32'hFC00_0000;
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            for (int i = 0; i < 20; i++) begin
                if (imem_req) bad_req++;
                if (instr_valid) bad_vld++;
                @(negedge clk);
            end
            check("trap_req_cycles",   32'(bad_req), 32'd0);
            check("trap_valid_cycles", 32'(bad_vld), 32'd0);
            check("trap_halted",       32'(halted),  32'd1);
            check("trap_opcode",       32'(opcode),  32'h3F);
            check("trap_pc",           pc_out,       32'h0);
        end
`else
        run_instr(32'hFC00_0000, 32'h0, 0, 0, 1'b0, 1'b0,
                  '{op:6'h3F, fn:6'h00, rs:5'd0,  rt:5'd0,  rd:5'd0,  imm:16'h0000, pc:32'h0});
        wait_req(ok);
        check("post_illegal_addr", imem_addr, 32'h4);
        check("no_trap_halted", 32'(halted), 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
